// File: rtl/msrv32_wb_arbiter.sv
// Register-file write-port arbiter: in-order pipeline writeback vs. an out-of-order
// multi-cycle unit, with a destination scoreboard, decode hazard stall and anti-starvation.
module msrv32_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        pipe_wr_en_in,
    input  logic [4:0]  pipe_rd_addr_in,
    input  logic [31:0] pipe_wb_data_in,
    input  logic        mc_issue_in,
    input  logic [4:0]  mc_issue_rd_in,
    input  logic        mc_valid_in,
    input  logic [4:0]  mc_rd_addr_in,
    input  logic [31:0] mc_data_in,
    output logic        mc_ready_out,
    input  logic [4:0]  dec_rs1_addr_in,
    input  logic [4:0]  dec_rs2_addr_in,
    input  logic [4:0]  dec_rd_addr_in,
    input  logic        dec_rd_wr_in,
    output logic        pipe_stall_out,
    output logic        rf_wr_en_out,
    output logic [4:0]  rf_rd_addr_out,
    output logic [31:0] rf_wr_data_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FORCE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]  w_wait_cnt_nxt;
    logic [CNT_W-1:0]  w_wait_cnt_inc;
    logic [31:0]       r_busy;
    logic [31:0]       w_busy_set;
    logic [31:0]       w_busy_clr;
    logic              w_force;
    logic              w_grant;
    logic              w_pipe_sel;
    logic              w_haz;

    assign w_force        = (r_state == S_FORCE);
    assign w_grant        = !ms_riscv32_mp_rst_in && mc_valid_in && (w_force || !pipe_wr_en_in);
    assign w_pipe_sel     = pipe_wr_en_in && !w_force;
    assign w_wait_cnt_inc = r_wait_cnt + CNT_W'(1);

    // Hazards see the pre-edge scoreboard, so a same-cycle grant still stalls decode once.
    assign w_haz = r_busy[dec_rs1_addr_in] || r_busy[dec_rs2_addr_in] ||
                   (dec_rd_wr_in && r_busy[dec_rd_addr_in]);

    assign mc_ready_out   = w_grant;
    assign pipe_stall_out = !ms_riscv32_mp_rst_in && (w_haz || w_force);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            S_IDLE, S_WAIT: begin
                if (!mc_valid_in || w_grant) begin
                    w_state_nxt    = S_IDLE;
                    w_wait_cnt_nxt = '0;
                end else begin
                    w_wait_cnt_nxt = w_wait_cnt_inc;
                    w_state_nxt    = (w_wait_cnt_inc == CNT_W'(STARVE_LIMIT)) ? S_FORCE : S_WAIT;
                end
            end
            S_FORCE: begin
                w_state_nxt    = S_IDLE;
                w_wait_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (ms_riscv32_mp_rst_in) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Set is applied after clear so a same-index issue and completion leaves the bit busy.
    assign w_busy_clr = w_grant ? (32'd1 << mc_rd_addr_in) : 32'd0;
    assign w_busy_set = (mc_issue_in && (mc_issue_rd_in != 5'd0)) ? (32'd1 << mc_issue_rd_in) : 32'd0;

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_busy_clr) | w_busy_set) & ~32'd1;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            rf_wr_en_out   <= 1'b0;
            rf_rd_addr_out <= '0;
            rf_wr_data_out <= '0;
        end else if (w_grant) begin
            rf_wr_en_out   <= (mc_rd_addr_in != 5'd0);
            rf_rd_addr_out <= mc_rd_addr_in;
            rf_wr_data_out <= mc_data_in;
        end else if (w_pipe_sel) begin
            rf_wr_en_out   <= (pipe_rd_addr_in != 5'd0);
            rf_rd_addr_out <= pipe_rd_addr_in;
            rf_wr_data_out <= pipe_wb_data_in;
        end else begin
            rf_wr_en_out   <= 1'b0;
        end
    end

endmodule

// File: doc/msrv32_wb_arbiter.md
Name: msrv32_wb_arbiter

Overview:
Arbitrates the single register-file write port between the in-order pipeline writeback (write-back mux output) and a multi-cycle functional unit (MC unit, e.g. divider) that completes out of order. Holds a 32-entry busy scoreboard for MC destinations, raises decode-stage stall on RAW/WAW hazards, and guarantees MC forward progress with an anti-starvation counter. Sits between the write-back mux select unit and the integer register file.

Parameters:
STARVE_LIMIT, 4, cycles an MC result may be refused before it is force-granted (1..15)
CNT_W, 4, width of the wait counter; must hold STARVE_LIMIT

Ports:
ms_riscv32_mp_clk_in  input  1  core clock; all state on rising edge
ms_riscv32_mp_rst_in  input  1  synchronous, active-high reset
pipe_wr_en_in  input  1  pipeline writeback request this cycle
pipe_rd_addr_in  input  5  pipeline destination register
pipe_wb_data_in  input  32  pipeline writeback data (wb mux output)
mc_issue_in  input  1  MC op issued this cycle
mc_issue_rd_in  input  5  destination of issued MC op
mc_valid_in  input  1  MC result valid
mc_rd_addr_in  input  5  MC result destination
mc_data_in  input  32  MC result data
mc_ready_out  output  1  MC result accepted this cycle (combinational)
dec_rs1_addr_in  input  5  decode-stage rs1
dec_rs2_addr_in  input  5  decode-stage rs2
dec_rd_addr_in  input  5  decode-stage rd
dec_rd_wr_in  input  1  decode-stage instruction writes rd
pipe_stall_out  output  1  freeze pipeline (combinational)
rf_wr_en_out  output  1  register-file write enable (registered)
rf_rd_addr_out  output  5  register-file write address (registered)
rf_wr_data_out  output  32  register-file write data (registered)

Behaviour:
- Reset (sync, high): rf_wr_en_out=0, rf_rd_addr_out=0, rf_wr_data_out=0, busy[31:0]=0, wait_cnt=0, state=IDLE. While reset is high, mc_ready_out=0 and pipe_stall_out=0. Reset mid-transaction discards any pending MC grant and all busy bits.
- FSM states: IDLE (no MC result pending), WAIT (mc_valid_in high, refused), FORCE (wait_cnt==STARVE_LIMIT).
  - IDLE: mc_valid_in & pipe_wr_en_in -> WAIT, wait_cnt=1. mc_valid_in & !pipe_wr_en_in -> grant, stay IDLE.
  - WAIT: grant when pipe_wr_en_in=0 -> IDLE, wait_cnt=0. Else wait_cnt+1; on reaching STARVE_LIMIT -> FORCE.
  - FORCE: mc_ready_out=1 and pipe_stall_out=1 unconditionally; pipeline write is not performed this cycle (pipeline holds it); next state IDLE, wait_cnt=0.
  - mc_valid_in dropping in WAIT: return to IDLE, wait_cnt=0 (protocol violation; no write).
- Grant: mc_ready_out = mc_valid_in & (state==FORCE | !pipe_wr_en_in). At most one write source per cycle; pipeline has priority except in FORCE.
- Write port: 1-cycle latency. The selected source's addr/data are registered next edge, and rf_wr_en_out=1 unless the address is 0. x0 writes are suppressed but still complete the handshake. With no source selected, rf_wr_en_out=0 and addr/data hold their last values.
- Scoreboard: mc_issue_in with mc_issue_rd_in!=0 sets busy[rd]. An MC grant clears busy[mc_rd_addr_in]. A set and clear of the same index in one cycle leaves the bit set. busy[0] is always 0.
- Hazard: haz = busy[dec_rs1] | busy[dec_rs2] | (dec_rd_wr_in & busy[dec_rd]). Index 0 is never a hazard. Evaluation uses current (pre-edge) busy state. A same-cycle MC grant does not clear the hazard until the next cycle.
- pipe_stall_out = haz | (state==FORCE).

Test Plan:
- Reset: hold rst 2 cycles with mc_valid_in=1, pipe_wr_en_in=1 -> all outputs 0, mc_ready_out=0. First cycle after release: mc_ready_out=0, state WAIT.
- Pipeline only: pipe_wr_en_in=1, rd=5, data=0xDEADBEEF -> next cycle rf_wr_en_out=1, addr=5, data=0xDEADBEEF. The same request with rd=0 -> rf_wr_en_out=0.
- Idle-slot MC: issue MC rd=7 (busy[7]=1). Then mc_valid_in=1, rd=7, data=0x12345678, pipe_wr_en_in=0 -> mc_ready_out=1 the same cycle, RF write the next cycle, busy[7]=0.
- Starvation: pipe_wr_en_in held 1, mc_valid_in=1 from cycle 0, STARVE_LIMIT=4 -> refused cycles 0-3; cycle 4 mc_ready_out=1, pipe_stall_out=1; cycle 5 RF write carries MC data; cycle 5 pipeline write resumes.
- Hazards: busy[9]=1, decode rs2=9 -> pipe_stall_out=1 until the cycle after MC grant for rd 9. Decode rd=9 with dec_rd_wr_in=1 -> stall. rs1=0 with busy set elsewhere -> no stall.
- Simultaneous set/clear: MC grant for rd=3 and mc_issue_in rd=3 in the same cycle -> busy[3] remains 1. Decode rs1=3 continues to stall.
